link_ctrl: RTL and testbench
============================

Name: link_ctrl

Overview:
Sequences the serial move link between two boards. It sits between game_fsm and the tx/rx UART pair.
- Outgoing: takes a local move from game_fsm, triggers tx, waits for an ACK byte and retransmits on timeout.
- Incoming: ACKs every received move byte, filters duplicate retransmissions and hands fresh moves to game_fsm.
- Owns the tx port: it is the only block that triggers tx, and it serialises ACKs and moves onto it.

Parameters:
PKT_LEN, 8, bits per link byte (matches tx/rx)
TX_GAP, 70000, clk_in cycles between tx triggers (>= one 10-bit frame at 9600 baud / 65 MHz)
ACK_TIMEOUT, 650000, cycles from move trigger to retransmit (10 ms)
MAX_RETRY, 3, retransmissions before link error
ACK_CODE, 8'hFF, ACK byte value; bytes >= 8'hF0 are control, never moves

Ports:
clk_in  input  1  65 MHz system clock
rst_in  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk_in)
local_move_valid_in  input  1  one-cycle pulse: local_move_in holds a move to send (game_fsm tx_ready)
local_move_in  input  PKT_LEN  move to send, sampled when local_move_valid_in=1
rx_ready_in  input  1  one-cycle pulse from rx: rx_data_in valid
rx_data_in  input  PKT_LEN  received byte
tx_trigger_out  output  1  one-cycle pulse to tx trigger_in
tx_val_out  output  PKT_LEN  byte to tx val_in, stable from trigger through GAP
rx_move_valid_out  output  1  one-cycle pulse: fresh remote move on rx_move_out
rx_move_out  output  PKT_LEN  last accepted remote move
move_acked_out  output  1  one-cycle pulse: outstanding local move acknowledged
busy_out  output  1  local move outstanding (captured, not yet acked)
link_err_out  output  1  retries exhausted; sticky until reset

Behaviour:
- Reset (rst_in=0 at posedge): all outputs 0, state IDLE, flags cleared.
  - Flags are ack_pending, outstanding and got_ack.
  - retry_cnt and timer are 0; last_rx is set to 8'hF0 (a non-move value, so the first move is always fresh).
  - Reset mid-transfer abandons everything immediately. A tx frame already started is not aborted.
- Local capture, independent of state:
  - local_move_valid_in while outstanding=0: latch the move, set outstanding and busy_out next cycle.
  - local_move_valid_in while outstanding=1 or in ERR: ignored.
- Rx decode, independent of state, on rx_ready_in:
  - data < 8'hF0 (a move): set ack_pending.
    - If data != last_rx: last_rx <= data, rx_move_out <= data, rx_move_valid_out pulses on the next cycle.
    - If data == last_rx: no pulse (duplicate); it is still ACKed.
  - data == ACK_CODE: set got_ack if outstanding, else ignore.
  - Other control codes: ignored.
- Simultaneous events: a local capture and an rx event in the same cycle are both processed.
- FSM:
  - IDLE:
    - ack_pending -> SEND_ACK (ACK takes priority over a move).
    - Otherwise, outstanding -> SEND_MOVE.
  - SEND_ACK (1 cycle): tx_val_out=ACK_CODE, tx_trigger_out=1, clear ack_pending. Record ret = WAIT_ACK if outstanding and the move was already sent, else IDLE. -> GAP.
  - SEND_MOVE (1 cycle): tx_val_out=latched move, tx_trigger_out=1, clear got_ack, timer<=0. -> GAP with ret=WAIT_ACK.
  - GAP:
    - gap counter runs 0..TX_GAP-1, then -> ret.
    - timer keeps running during GAP.
    - got_ack may be set during GAP; it is honoured in WAIT_ACK.
  - WAIT_ACK, priority in this order:
    - got_ack: clear outstanding and retry_cnt, pulse move_acked_out -> IDLE.
    - ack_pending: -> SEND_ACK.
    - timer == ACK_TIMEOUT-1 and retry_cnt < MAX_RETRY: retry_cnt++ -> SEND_MOVE.
    - timer == ACK_TIMEOUT-1 and retry_cnt == MAX_RETRY: -> ERR.
  - ERR: link_err_out=1 and busy_out stays 1 until reset. Rx moves still pulse rx_move_valid_out, but no ACKs are sent.
- Timing and width rules:
  - Latency from local_move_valid_in to tx_trigger_out is 2 cycles when idle (capture cycle, then IDLE decision, then trigger).
  - Consecutive triggers are never less than TX_GAP+1 cycles apart.
  - timer and gap counters are sized with $clog2 of their parameter and saturate rather than wrap.

Test Plan:
(Use TX_GAP=20, ACK_TIMEOUT=100, MAX_RETRY=3.)
1. Reset held at 0 for 3 cycles with random inputs -> all outputs 0. Release, then pulse local move 8'h34 -> tx_trigger_out 2 cycles later with tx_val_out=8'h34; busy_out=1.
2. Send 8'h34, inject rx 8'hFF at cycle 30 -> move_acked_out pulse, busy_out=0, no further triggers.
3. Send 8'h34, no ACK -> retriggers of 8'h34 at +100, +200, +300 cycles from the first trigger; link_err_out=1 at +400, then no triggers.
4. Inject rx 8'h56 twice, 200 cycles apart -> rx_move_valid_out pulses once, rx_move_out=8'h56; two ACK triggers of 8'hFF, at least 21 cycles apart.
5. Local 8'h12 and rx 8'h77 in the same cycle -> ACK trigger first, move trigger 21 cycles later; both the rx pulse and busy_out asserted.
6. Second local pulse (8'h99) while 8'h12 is outstanding -> ignored; only 8'h12 is ever transmitted. Rx 8'hFF with nothing outstanding -> no move_acked_out.

Source files
------------

// File: rtl/link_ctrl.sv
// Serial move-link sequencer between game_fsm and the tx/rx UART pair.
// Sole owner of the tx port: it interleaves ACK bytes and local moves and retransmits moves that are not acknowledged.
module link_ctrl #(
    parameter int                 PKT_LEN     = 8,
    parameter int                 TX_GAP      = 70000,
    parameter int                 ACK_TIMEOUT = 650000,
    parameter int                 MAX_RETRY   = 3,
    parameter logic [PKT_LEN-1:0] ACK_CODE    = {PKT_LEN{1'b1}}
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               local_move_valid_in,
    input  logic [PKT_LEN-1:0] local_move_in,
    input  logic               rx_ready_in,
    input  logic [PKT_LEN-1:0] rx_data_in,
    output logic               tx_trigger_out,
    output logic [PKT_LEN-1:0] tx_val_out,
    output logic               rx_move_valid_out,
    output logic [PKT_LEN-1:0] rx_move_out,
    output logic               move_acked_out,
    output logic               busy_out,
    output logic               link_err_out
);

    // state       | meaning
    // S_IDLE      | nothing on the wire; pick ACK first, then an outstanding move
    // S_SEND_ACK  | one-cycle tx trigger with ACK_CODE
    // S_SEND_MOVE | one-cycle tx trigger with the latched local move
    // S_GAP       | hold tx_val while the frame shifts out, then go to ret_q
    // S_WAIT_ACK  | move sent, waiting for ACK or the retransmit timeout
    // S_ERR       | retries exhausted; sticky until reset

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_ACK, S_SEND_MOVE, S_GAP, S_WAIT_ACK, S_ERR
    } state_t;

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]      TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0]      GAP_LAST   = GW'(TX_GAP - 1);
    localparam logic [RW-1:0]      RETRY_MAX  = RW'(MAX_RETRY);
    // Bytes with the top nibble all ones are control codes, never moves.
    localparam logic [PKT_LEN-1:0] CTRL_MIN   = {4'hF, {(PKT_LEN-4){1'b0}}};

    state_t             state_q, state_d, ret_q, ret_d;
    logic               ack_pending_q, ack_pending_d;
    logic               outstanding_q, outstanding_d;
    logic               got_ack_q, got_ack_d;
    logic               move_sent_q, move_sent_d;
    logic [RW-1:0]      retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [PKT_LEN-1:0] last_rx_q, last_rx_d;
    logic [PKT_LEN-1:0] move_q, move_d;
    logic [PKT_LEN-1:0] rx_move_q, rx_move_d;
    logic               rx_move_valid_q, rx_move_valid_d;
    logic [PKT_LEN-1:0] tx_val_q, tx_val_d;
    logic               tx_trigger, move_acked;

    always_comb begin
        state_d         = state_q;
        ret_d           = ret_q;
        ack_pending_d   = ack_pending_q;
        outstanding_d   = outstanding_q;
        got_ack_d       = got_ack_q;
        move_sent_d     = move_sent_q;
        retry_cnt_d     = retry_cnt_q;
        last_rx_d       = last_rx_q;
        move_d          = move_q;
        rx_move_d       = rx_move_q;
        rx_move_valid_d = 1'b0;
        tx_val_d        = tx_val_q;
        tx_trigger      = 1'b0;
        move_acked      = 1'b0;
        timer_d         = (timer_q == TIMER_LAST) ? timer_q : timer_q + TW'(1);
        gap_d           = (gap_q == GAP_LAST) ? gap_q : gap_q + GW'(1);

        case (state_q)
            S_IDLE: begin
                if (ack_pending_q)      state_d = S_SEND_ACK;
                else if (outstanding_q) state_d = S_SEND_MOVE;
            end
            S_SEND_ACK: begin
                tx_trigger    = 1'b1;
                ack_pending_d = 1'b0;
                ret_d         = (outstanding_q && move_sent_q) ? S_WAIT_ACK : S_IDLE;
                state_d       = S_GAP;
            end
            S_SEND_MOVE: begin
                tx_trigger  = 1'b1;
                got_ack_d   = 1'b0;
                move_sent_d = 1'b1;
                ret_d       = S_WAIT_ACK;
                state_d     = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = ret_q;
            end
            S_WAIT_ACK: begin
                if (got_ack_q) begin
                    outstanding_d = 1'b0;
                    retry_cnt_d   = '0;
                    got_ack_d     = 1'b0;
                    move_sent_d   = 1'b0;
                    move_acked    = 1'b1;
                    state_d       = S_IDLE;
                end else if (ack_pending_q) begin
                    state_d = S_SEND_ACK;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_cnt_q < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt_q + RW'(1);
                        state_d     = S_SEND_MOVE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // tx_val and the counters are loaded as a send state is entered, so
        // the byte is already stable in the trigger cycle.
        if (state_d == S_SEND_ACK) begin
            tx_val_d = ACK_CODE;
            gap_d    = '0;
        end
        if (state_d == S_SEND_MOVE) begin
            tx_val_d = move_q;
            gap_d    = '0;
            timer_d  = '0;
        end

        if (local_move_valid_in && !outstanding_q && state_q != S_ERR) begin
            move_d        = local_move_in;
            outstanding_d = 1'b1;
        end

        if (rx_ready_in) begin
            if (rx_data_in < CTRL_MIN) begin
                ack_pending_d = 1'b1;
                if (rx_data_in != last_rx_q) begin
                    last_rx_d       = rx_data_in;
                    rx_move_d       = rx_data_in;
                    rx_move_valid_d = 1'b1;
                end
            end else if (rx_data_in == ACK_CODE && outstanding_q && outstanding_d) begin
                got_ack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= S_IDLE;
            ret_q           <= S_IDLE;
            ack_pending_q   <= 1'b0;
            outstanding_q   <= 1'b0;
            got_ack_q       <= 1'b0;
            move_sent_q     <= 1'b0;
            retry_cnt_q     <= '0;
            timer_q         <= '0;
            gap_q           <= '0;
            last_rx_q       <= CTRL_MIN;
            move_q          <= '0;
            rx_move_q       <= '0;
            rx_move_valid_q <= 1'b0;
            tx_val_q        <= '0;
        end else begin
            state_q         <= state_d;
            ret_q           <= ret_d;
            ack_pending_q   <= ack_pending_d;
            outstanding_q   <= outstanding_d;
            got_ack_q       <= got_ack_d;
            move_sent_q     <= move_sent_d;
            retry_cnt_q     <= retry_cnt_d;
            timer_q         <= timer_d;
            gap_q           <= gap_d;
            last_rx_q       <= last_rx_d;
            move_q          <= move_d;
            rx_move_q       <= rx_move_d;
            rx_move_valid_q <= rx_move_valid_d;
            tx_val_q        <= tx_val_d;
        end
    end

    assign tx_trigger_out    = tx_trigger;
    assign tx_val_out        = tx_val_q;
    assign rx_move_valid_out = rx_move_valid_q;
    assign rx_move_out       = rx_move_q;
    assign move_acked_out    = move_acked;
    assign busy_out          = outstanding_q;
    assign link_err_out      = (state_q == S_ERR);

endmodule

// File: tb/tb_link_ctrl.sv
// Self-checking bench for link_ctrl with short timing parameters.
// Event logs (trigger, rx pulse, ack pulse, error) are compared to expected cycle numbers and values.
module tb_link_ctrl;
    localparam int TX_GAP = 20, ACK_TO = 100, MAX_RETRY = 3;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       local_move_valid_in = 1'b0;
    logic [7:0] local_move_in = '0;
    logic       rx_ready_in = 1'b0;
    logic [7:0] rx_data_in = '0;
    logic       tx_trigger_out, rx_move_valid_out, move_acked_out, busy_out, link_err_out;
    logic [7:0] tx_val_out, rx_move_out;

    link_ctrl #(.PKT_LEN(8), .TX_GAP(TX_GAP), .ACK_TIMEOUT(ACK_TO), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .local_move_valid_in(local_move_valid_in), .local_move_in(local_move_in),
        .rx_ready_in(rx_ready_in), .rx_data_in(rx_data_in),
        .tx_trigger_out(tx_trigger_out), .tx_val_out(tx_val_out),
        .rx_move_valid_out(rx_move_valid_out), .rx_move_out(rx_move_out),
        .move_acked_out(move_acked_out), .busy_out(busy_out), .link_err_out(link_err_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;
    int trig_t[$]; int trig_v[$];
    int rxp_t[$];  int rxp_v[$];
    int ack_t[$];
    int err_t = -1;

    always @(negedge clk_in) begin
        if (tx_trigger_out) begin
            trig_t.push_back(cyc);
            trig_v.push_back(int'(tx_val_out));
        end
        if (rx_move_valid_out) begin
            rxp_t.push_back(cyc);
            rxp_v.push_back(int'(rx_move_out));
        end
        if (move_acked_out) ack_t.push_back(cyc);
        if (link_err_out && err_t < 0) err_t = cyc;
    end

    typedef struct {
        logic [7:0] data;
        int         exp_pulse;
        int         exp_ack;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic clear_logs;
        trig_t.delete(); trig_v.delete();
        rxp_t.delete();  rxp_v.delete();
        ack_t.delete();
        err_t = -1;
    endtask

    task automatic do_reset;
        rst_in = 1'b0;
        local_move_valid_in = 1'b0;
        rx_ready_in = 1'b0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
        end
        rst_in = 1'b1;
        clear_logs();
    endtask

    task automatic local_pulse(input logic [7:0] d);
        local_move_valid_in = 1'b1;
        local_move_in = d;
        @(posedge clk_in);
        #1;
        local_move_valid_in = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_ready_in = 1'b1;
        rx_data_in = d;
        @(posedge clk_in);
        #1;
        rx_ready_in = 1'b0;
    endtask

    // From IDLE: a move byte pulses rx_move_valid one cycle later (if fresh)
    // and is ACKed on tx two cycles later; control bytes do neither.
    task automatic apply_rx_vec(input logic [7:0] d, input int exp_pulse, input int exp_ack, input string name);
        int n, p0, a0;
        p0 = rxp_t.size();
        a0 = trig_t.size();
        n = cyc;
        rx_pulse(d);
        wait_until(n + 28);
        check($sformatf("%s_pulse_cnt", name), rxp_t.size() - p0, exp_pulse);
        if (exp_pulse != 0 && rxp_t.size() > p0) begin
            check($sformatf("%s_pulse_time", name), rxp_t[p0], n + 1);
            check($sformatf("%s_rx_move", name), rxp_v[p0], int'(d));
        end
        check($sformatf("%s_ack_cnt", name), trig_t.size() - a0, exp_ack);
        if (exp_ack != 0 && trig_t.size() > a0) begin
            check($sformatf("%s_ack_time", name), trig_t[a0], n + 2);
            check($sformatf("%s_ack_val", name), trig_v[a0], 8'hFF);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected < 100000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, cnt99;
        logic [7:0] b, prev, model_last;
        int is_move, fresh;

        vecs[0] = '{8'h10, 1, 1};
        vecs[1] = '{8'h10, 0, 1};
        vecs[2] = '{8'hFF, 0, 0};
        vecs[3] = '{8'hF0, 0, 0};
        vecs[4] = '{8'hEF, 1, 1};
        vecs[5] = '{8'h00, 1, 1};
        vecs[6] = '{8'hF5, 0, 0};
        vecs[7] = '{8'h00, 0, 1};
        vecs[8] = '{8'h10, 1, 1};

        // 1: reset with random inputs, then first move
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            local_move_valid_in = 1'($urandom_range(0, 1));
            local_move_in = 8'($urandom);
            rx_ready_in = 1'($urandom_range(0, 1));
            rx_data_in = 8'($urandom);
            @(posedge clk_in);
            #1;
            check($sformatf("reset_outputs_%0d", i),
                  int'({tx_trigger_out, tx_val_out, rx_move_valid_out, rx_move_out,
                        move_acked_out, busy_out, link_err_out}), 0);
        end
        local_move_valid_in = 1'b0;
        rx_ready_in = 1'b0;
        rst_in = 1'b1;
        clear_logs();

        n = cyc;
        local_pulse(8'h34);
        wait_until(n + 3);
        t = n + 2;
        check("t1_trig_cnt", trig_t.size(), 1);
        if (trig_t.size() > 0) begin
            check("t1_trig_time", trig_t[0], t);
            check("t1_trig_val", trig_v[0], 8'h34);
        end
        check("t1_busy", int'(busy_out), 1);
        wait_until(t + 15);
        check("t1_val_hold", int'(tx_val_out), 8'h34);

        // 2: ACK at trigger+30
        wait_until(t + 30);
        rx_pulse(8'hFF);
        wait_until(t + 40);
        check("t2_acked_cnt", ack_t.size(), 1);
        check("t2_busy", int'(busy_out), 0);
        wait_until(t + 350);
        check("t2_no_retx", trig_t.size(), 1);
        check("t2_no_err", int'(link_err_out), 0);

        // 3: no ACK -> three retries then error
        do_reset();
        n = cyc;
        local_pulse(8'h34);
        t = n + 2;
        wait_until(t + 460);
        check("t3_trig_cnt", trig_t.size(), MAX_RETRY + 1);
        for (int i = 0; i <= MAX_RETRY; i++) begin
            if (i < trig_t.size()) begin
                check($sformatf("t3_trig%0d_time", i), trig_t[i], t + ACK_TO * i);
                check($sformatf("t3_trig%0d_val", i), trig_v[i], 8'h34);
            end
        end
        check("t3_err_time", err_t, t + ACK_TO * (MAX_RETRY + 1));
        check("t3_err", int'(link_err_out), 1);
        check("t3_busy", int'(busy_out), 1);
        local_pulse(8'h55);
        rx_pulse(8'h21);
        wait_until(t + 520);
        check("t3_err_silent", trig_t.size(), MAX_RETRY + 1);
        check("t3_err_rx_pulse", rxp_t.size(), 1);

        // 4: duplicate remote move
        do_reset();
        n = cyc;
        rx_pulse(8'h56);
        wait_until(n + 200);
        rx_pulse(8'h56);
        wait_until(n + 240);
        check("t4_pulse_cnt", rxp_t.size(), 1);
        check("t4_rx_move", int'(rx_move_out), 8'h56);
        check("t4_ack_cnt", trig_t.size(), 2);
        if (trig_t.size() == 2) begin
            check("t4_ack0_val", trig_v[0], 8'hFF);
            check("t4_ack1_val", trig_v[1], 8'hFF);
            check("t4_ack_spacing", int'(trig_t[1] - trig_t[0] >= TX_GAP + 1), 1);
            check("t4_ack1_time", trig_t[1], n + 202);
        end

        // 5: local move and remote move in the same cycle
        do_reset();
        n = cyc;
        local_move_valid_in = 1'b1;
        local_move_in = 8'h12;
        rx_ready_in = 1'b1;
        rx_data_in = 8'h77;
        @(posedge clk_in);
        #1;
        local_move_valid_in = 1'b0;
        rx_ready_in = 1'b0;
        wait_until(n + 30);
        check("t5_trig_cnt", trig_t.size(), 2);
        if (trig_t.size() == 2) begin
            check("t5_ack_time", trig_t[0], n + 2);
            check("t5_ack_val", trig_v[0], 8'hFF);
            check("t5_move_time", trig_t[1], n + 2 + TX_GAP + 1);
            check("t5_move_val", trig_v[1], 8'h12);
        end
        check("t5_pulse_cnt", rxp_t.size(), 1);
        if (rxp_t.size() > 0) check("t5_pulse_val", rxp_v[0], 8'h77);
        check("t5_busy", int'(busy_out), 1);

        // 6: second local move ignored; stray ACK ignored
        wait_until(n + 40);
        local_pulse(8'h99);
        wait_until(n + 60);
        rx_pulse(8'hFF);
        wait_until(n + 70);
        check("t6_acked_cnt", ack_t.size(), 1);
        check("t6_busy", int'(busy_out), 0);
        rx_pulse(8'hFF);
        wait_until(n + 300);
        check("t6_stray_ack", ack_t.size(), 1);
        check("t6_trig_cnt", trig_t.size(), 2);
        cnt99 = 0;
        foreach (trig_v[i]) if (trig_v[i] == 8'h99) cnt99++;
        check("t6_no_99", cnt99, 0);

        // table vectors: duplicate filter and control-code boundaries
        do_reset();
        for (int i = 0; i < 9; i++)
            apply_rx_vec(vecs[i].data, vecs[i].exp_pulse, vecs[i].exp_ack, $sformatf("vec%0d", i));

        // random remote bytes against a last-move dedup model
        do_reset();
        model_last = 8'hF0;
        prev = 8'h00;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) b = prev;
            else if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(8'hF0, 8'hFF));
            else b = 8'($urandom);
            is_move = (b < 8'hF0) ? 1 : 0;
            fresh = (is_move != 0 && b != model_last) ? 1 : 0;
            if (fresh != 0) model_last = b;
            apply_rx_vec(b, fresh, is_move, $sformatf("rnd%0d_%02h", i, b));
            prev = b;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
